inv_shift_rows_stage: RTL
=========================

Name: inv_shift_rows_stage

Overview:
- Registered AES InvShiftRows stage for the decryption datapath; the inverse counterpart of the encryption-side ShiftRows register.
- Accepts one 128-bit state per valid/ready handshake, applies InvShiftRows, and buffers results in a small in-order FIFO.
- Carries a round-tag sideband so the downstream InvSubBytes/AddRoundKey logic can track round numbers.

Parameters:
- DEPTH, 2, output buffer entries; power of two, minimum 2.
- TAG_W, 4, width of the round-tag sideband carried with each state.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; empties the buffer on the next edge.
- in_valid  input  1  upstream state valid.
- in_ready  output  1  stage can accept a state this cycle.
- in_data  input  128  AES state. Byte i is in_data[127-8i -: 8]; column-major, so byte i = s(r=i%4, c=i/4).
- in_tag  input  TAG_W  round tag.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream accepts the head entry.
- out_data  output  128  InvShiftRows(in_data) for the head entry.
- out_tag  output  TAG_W  tag of the head entry.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Transform is combinational on the push path: out s(r,c) = in s(r,(c-r) mod 4). Row 0 is unchanged. Rows 1/2/3 rotate right by 1/2/3 byte positions within the row.
- Storage:
  - DEPTH x (128+TAG_W) entry array.
  - Write pointer and read pointer, $clog2(DEPTH) bits each, wrapping modulo DEPTH.
  - count register.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends only on registered state, with no combinational path from out_ready.
- out_valid = (count != 0). out_data/out_tag are read from the entry at the read pointer.
- Latency: a state pushed at edge N is visible on out_* after edge N; earliest pop is at edge N+1. There is no fall-through path.
- Per-edge update:
  - Push only: write entry, advance the write pointer, count+1.
  - Pop only: advance the read pointer, count-1.
  - Push and pop together: allowed only when count is 1..DEPTH-1 (push needs !full, pop needs !empty). Both pointers advance and count is unchanged.
  - When full, in_ready is low, so no push happens even if pop is high that cycle. in_ready rises on the following cycle.
  - When empty, out_valid is low; out_ready is ignored.
- Entries leave strictly in push order. Tags travel unchanged with their data.
- flush has priority over push and pop in the same cycle. Pointers and count go to 0, and that cycle's push is discarded. in_ready is still driven from the registered count during the flush cycle, so the upstream handshake completes and the data is dropped.
- Outputs whose values are unspecified:
  - Stale entry contents are not cleared and are not observable while out_valid=0.
  - out_data/out_tag are don't-care while out_valid=0. The bench must not check them.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers and count go to 0, so out_valid=0, in_ready=1, count=0.
  - Entry storage is not reset.
  - out_data and out_tag reset to 0 (reading entry 0 under a reset-cleared array is not required; the output mux is forced to 0 when count==0).
  - In-flight states are lost. After reset deassertion the first accepted state appears one edge later.
- DEPTH=2 sustains one state per cycle when out_ready is held high.

Decomposition:
- Shared package aes_pkg:
  - AES_STATE_W=128.
  - state byte-index helper constants.
  - inv_shift_rows function (pure combinational mapping), reused later by the full inverse round.
- One natural sub-module: sync_fifo_buf, a generic DEPTH x W in-order buffer with count, push/pop/flush. This block instantiates it after applying the function.

Test Plan:
- Single transfer: in_data=000102030405060708090a0b0c0d0e0f, tag=3, out_ready=1 -> one cycle later out_valid=1, out_data=000d0a07_04010e0b_0805020f_0c090603, out_tag=3; popped next edge; count returns to 0.
- Round trip: feed the result of the forward ShiftRows of random states -> out_data equals the original state, for 1000 random vectors.
- Backpressure: out_ready=0, push 3 states, DEPTH=2 -> in_ready=0 after 2 pushes, count=2, third held upstream. Raise out_ready -> outputs emerge in order with tags 0,1,2.
- Streaming: in_valid=1, out_ready=1 for 16 cycles -> 16 outputs on consecutive cycles, count never exceeds 1, no drops.
- Flush priority: count=2, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0; the flush-cycle input never appears.
- Async reset mid-stream: assert reset between edges with count=1 -> out_valid=0, in_ready=1, count=0 immediately. Resume -> first new state out after one edge.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state constants and the InvShiftRows byte mapping
package aes_pkg;
  localparam int AES_STATE_W = 128;
  localparam int AES_NB = 4;
  localparam int AES_ROWS = 4;
  function automatic int state_byte_msb(input int r, input int c);
    return AES_STATE_W - 1 - 8 * (r + AES_ROWS * c);
  endfunction
  function automatic logic [AES_STATE_W-1:0] inv_shift_rows(input logic [AES_STATE_W-1:0] s);
    logic [AES_STATE_W-1:0] o;
    o = '0;
    for (int r = 0; r < AES_ROWS; r++)
      for (int c = 0; c < AES_NB; c++)
        o[state_byte_msb(r, c) -: 8] = s[state_byte_msb(r, (c - r + AES_NB) % AES_NB) -: 8];
    return o;
  endfunction
endpackage

// File: rtl/sync_fifo_buf.sv
// sync_fifo_buf: DEPTH x W in-order buffer with occupancy count and flush
module sync_fifo_buf #(
  parameter int DEPTH = 2,
  parameter int W = 132
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign in_ready = count != CW'(DEPTH);
  assign out_valid = count != '0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_data = out_valid ? mem[rd_ptr] : '0;
  // pointers and occupancy; flush wins over any handshake in the same cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  // entry storage is deliberately left unreset
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= in_data;
endmodule

// File: rtl/inv_shift_rows_stage.sv
// inv_shift_rows_stage: registered AES InvShiftRows with tagged in-order output buffer
module inv_shift_rows_stage
  import aes_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AES_STATE_W-1:0]   in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AES_STATE_W-1:0]   out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count
);
  logic [AES_STATE_W+TAG_W-1:0] wr_entry, rd_entry;
  assign wr_entry = {inv_shift_rows(in_data), in_tag};
  assign {out_data, out_tag} = rd_entry;
  sync_fifo_buf #(.DEPTH(DEPTH), .W(AES_STATE_W + TAG_W)) u_buf (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(wr_entry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(rd_entry),
    .count(count)
  );
endmodule
